// File: rtl/uart_byte_fifo_pkg.sv
// Shared types and defaults for the UART byte FIFO between uart_rx and uart_tx.
package uart_byte_fifo_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;
  localparam int DATA_W_DEFAULT     = 8;

  // Two-bit codes leave room for illegal values that the FSMs map back to idle.
  typedef enum logic [1:0] {
    RX_IDLE = 2'b01,
    RX_ACK  = 2'b10
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'b01,
    TX_WAIT = 2'b10
  } tx_state_t;

endpackage

// File: rtl/fifo_mem_sync.sv
// Register array with one write port and a registered read port (BRAM-friendly).
module fifo_mem_sync #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array has no reset so it can map onto block RAM; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only changes on a launch, so it holds the byte for the whole transmission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO from uart_rx handshake to uart_tx launch/done pacing.
// Optional UART_FIFO_STATS_EN adds high-water and saturating drop counters.
module uart_byte_fifo
  import uart_byte_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT
) (
  input  logic                  i_uart_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_data_valid,
  input  logic [DATA_W-1:0]     i_rx_byte,
  output logic                  o_rx_ready,
  output logic [DATA_W-1:0]     o_tx_byte,
  output logic                  o_tx_data_valid,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow
`ifdef UART_FIFO_STATS_EN
  ,
  output logic [DEPTH_LOG2:0]   o_high_water,
  output logic [15:0]           o_drop_count
`endif
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  rx_state_t             rx_state;
  tx_state_t             tx_state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  rx_take;
  logic                  push;
  logic                  drop;
  logic                  pop;

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == FULL_COUNT);

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign rx_take = (rx_state == RX_IDLE) && i_rx_data_valid;
  assign push    = rx_take && !o_full;
  assign drop    = rx_take && o_full;
  assign pop     = (tx_state == TX_IDLE) && !o_empty && !i_tx_active;

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    count_next = o_count;
    if (push && !pop)      count_next = o_count + 1'b1;
    else if (pop && !push) count_next = o_count - 1'b1;
  end

  fifo_mem_sync #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (i_uart_clk),
    .rst_n   (i_rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (i_rx_byte),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (o_tx_byte)
  );

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_count <= count_next;
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state   <= RX_IDLE;
      o_rx_ready <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          o_rx_ready <= i_rx_data_valid;
          if (i_rx_data_valid) rx_state <= RX_ACK;
        end
        RX_ACK: begin
          o_rx_ready <= 1'b0;
          if (!i_rx_data_valid) rx_state <= RX_IDLE;
        end
        default: begin
          o_rx_ready <= 1'b0;
          rx_state   <= RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state        <= TX_IDLE;
      o_tx_data_valid <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          o_tx_data_valid <= pop;
          if (pop) tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          o_tx_data_valid <= 1'b0;
          if (i_tx_done) tx_state <= TX_IDLE;
        end
        default: begin
          o_tx_data_valid <= 1'b0;
          tx_state        <= TX_IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n)              o_overflow <= 1'b0;
    else if (drop)             o_overflow <= 1'b1;
    else if (i_clear_overflow) o_overflow <= 1'b0;
  end

`ifdef UART_FIFO_STATS_EN
  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_high_water <= '0;
      o_drop_count <= '0;
    end else begin
      if (i_clear_overflow || (count_next > o_high_water)) o_high_water <= count_next;
      if (i_clear_overflow)                 o_drop_count <= {15'd0, drop};
      else if (drop && (o_drop_count != 16'hFFFF)) o_drop_count <= o_drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed self-checking bench for uart_byte_fifo (default build; stats ports wired when enabled).
module tb_uart_byte_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_rx_data_valid = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic       i_tx_active = 1'b0;
  logic       i_tx_done = 1'b0;
  logic       i_clear_overflow = 1'b0;
  logic       o_rx_ready;
  logic [7:0] o_tx_byte;
  logic       o_tx_data_valid;
  logic [4:0] o_count;
  logic       o_empty;
  logic       o_full;
  logic       o_overflow;
`ifdef UART_FIFO_STATS_EN
  logic [4:0]  o_high_water;
  logic [15:0] o_drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_byte_fifo dut (
    .i_uart_clk       (clk),
    .i_rst_n          (rst_n),
    .i_rx_data_valid  (i_rx_data_valid),
    .i_rx_byte        (i_rx_byte),
    .o_rx_ready       (o_rx_ready),
    .o_tx_byte        (o_tx_byte),
    .o_tx_data_valid  (o_tx_data_valid),
    .i_tx_active      (i_tx_active),
    .i_tx_done        (i_tx_done),
    .o_count          (o_count),
    .o_empty          (o_empty),
    .o_full           (o_full),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow)
`ifdef UART_FIFO_STATS_EN
    ,
    .o_high_water     (o_high_water),
    .o_drop_count     (o_drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behaves like uart_rx: hold valid until the one-cycle ready pulse.
  task automatic send(input logic [7:0] b, input string tag);
    int n = 0;
    i_rx_byte       = b;
    i_rx_data_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!o_rx_ready && n < 20);
    check({tag, "_ack"}, o_rx_ready, 1);
    i_rx_data_valid = 1'b0;
    tick();
  endtask

  // Behaves like uart_tx: wait for launch, check the byte, then report done.
  task automatic recv(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!o_tx_data_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_launch"}, o_tx_data_valid, 1);
    check({tag, "_byte"}, o_tx_byte, exp);
    tick();
    check({tag, "_pulse"}, o_tx_data_valid, 0);
    check({tag, "_hold"}, o_tx_byte, exp);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  initial begin
    int pulses;

    // Reset values
    #1 rst_n = 1'b0;
    tick();
    check("rst_count", o_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_ready", o_rx_ready, 0);
    check("rst_txv", o_tx_data_valid, 0);
    check("rst_byte", o_tx_byte, 8'h00);
    check("rst_ovf", o_overflow, 0);
    rst_n = 1'b1;
    tick();

    // 1: single byte, latency and pulse widths
    i_rx_byte = 8'hA5;
    i_rx_data_valid = 1'b1;
    tick();
    check("t1_ready_hi", o_rx_ready, 1);
    check("t1_count1", o_count, 1);
    check("t1_not_empty", o_empty, 0);
    check("t1_no_launch_yet", o_tx_data_valid, 0);
    i_rx_data_valid = 1'b0;
    tick();
    check("t1_ready_lo", o_rx_ready, 0);
    check("t1_launch", o_tx_data_valid, 1);
    check("t1_byte", o_tx_byte, 8'hA5);
    check("t1_count0", o_count, 0);
    tick();
    check("t1_pulse", o_tx_data_valid, 0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;

    // 2: fill to 16 while tx busy
    i_tx_active = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), "t2_fill");
    check("t2_full", o_full, 1);
    check("t2_count", o_count, 16);
    check("t2_ovf_clear", o_overflow, 0);

    // 3: overflow, set-wins, clear
    send(8'hFF, "t3_drop");
    check("t3_ovf", o_overflow, 1);
    check("t3_count", o_count, 16);
    i_clear_overflow = 1'b1;
    i_rx_byte = 8'hFE;
    i_rx_data_valid = 1'b1;
    tick();
    check("t3_setwins_ack", o_rx_ready, 1);
    check("t3_setwins", o_overflow, 1);
    i_clear_overflow = 1'b0;
    i_rx_data_valid = 1'b0;
    tick();
    i_clear_overflow = 1'b1;
    tick();
    i_clear_overflow = 1'b0;
    check("t3_ovf_cleared", o_overflow, 0);
    i_tx_active = 1'b0;
    for (int i = 0; i < 16; i++) recv(8'(i), "t2_drain");
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_tx_data_valid) pulses++;
    end
    check("t3_ff_never_sent", pulses, 0);
    check("t3_empty", o_empty, 1);

    // 4: valid held 5 cycles -> one write
    i_tx_active = 1'b1;
    i_rx_byte = 8'h44;
    i_rx_data_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_rx_ready) pulses++;
    end
    check("t4_one_ack", pulses, 1);
    i_rx_data_valid = 1'b0;
    tick();
    check("t4_count", o_count, 1);

    // 5: simultaneous push/pop at count 3, across pointer wrap
    send(8'h11, "t5_a");
    send(8'h22, "t5_b");
    check("t5_count3", o_count, 3);
    i_rx_byte = 8'h33;
    i_rx_data_valid = 1'b1;
    i_tx_active = 1'b0;
    tick();
    check("t5_pp_ack", o_rx_ready, 1);
    check("t5_pp_launch", o_tx_data_valid, 1);
    check("t5_pp_byte", o_tx_byte, 8'h44);
    check("t5_pp_count", o_count, 3);
    i_rx_data_valid = 1'b0;
    i_tx_active = 1'b1;
    tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    i_tx_active = 1'b0;
    recv(8'h11, "t5_r1");
    recv(8'h22, "t5_r2");
    recv(8'h33, "t5_r3");
    tick();
    check("t5_empty", o_empty, 1);

    // Push while full with a same-cycle pop is still dropped
    i_tx_active = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), "tf_fill");
    i_rx_byte = 8'hEE;
    i_rx_data_valid = 1'b1;
    i_tx_active = 1'b0;
    tick();
    check("tf_ack", o_rx_ready, 1);
    check("tf_launch", o_tx_data_valid, 1);
    check("tf_byte", o_tx_byte, 8'h80);
    check("tf_count15", o_count, 15);
    check("tf_ovf", o_overflow, 1);
    i_rx_data_valid = 1'b0;
    tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    for (int i = 1; i < 16; i++) recv(8'h80 + 8'(i), "tf_drain");
    tick();
    check("tf_empty", o_empty, 1);

    // 6: reset while in TX_WAIT with 5 queued
    i_tx_active = 1'b1;
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), "t6_fill");
    i_tx_active = 1'b0;
    tick();
    check("t6_launch", o_tx_data_valid, 1);
    check("t6_count5", o_count, 5);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_count", o_count, 0);
    check("t6_empty", o_empty, 1);
    check("t6_full", o_full, 0);
    check("t6_txv", o_tx_data_valid, 0);
    check("t6_byte", o_tx_byte, 8'h00);
    check("t6_ovf", o_overflow, 0);
    check("t6_ready", o_rx_ready, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_tx_data_valid) pulses++;
    end
    check("t6_no_launch", pulses, 0);
    send(8'h77, "t6_new");
    recv(8'h77, "t6_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
Name: uart_byte_fifo

Overview:
- Buffering stage directly downstream of uart_rx and directly upstream of uart_tx.
- Accepts received bytes through the uart_rx valid/ready handshake and stores them in a synchronous circular FIFO.
- Replays stored bytes to uart_tx one at a time, gated on tx idle/done.
- Decouples bursty host traffic from transmit pacing and replaces the single-byte holding register in the loopback top.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16).
- DATA_W, 8, byte width; fixed at 8 for UART use.

Ports:
- i_uart_clk  input  1  system clock (16 MHz on board)
- i_rst_n  input  1  asynchronous active-low reset
- i_rx_data_valid  input  1  from uart_rx o_data_valid; held high until acknowledged
- i_rx_byte  input  8  from uart_rx o_byte_out
- o_rx_ready  output  1  to uart_rx i_rx_ready; one-cycle acknowledge pulse
- o_tx_byte  output  8  to uart_tx i_byte_in; stable from launch until i_tx_done
- o_tx_data_valid  output  1  to uart_tx i_data_valid; one-cycle launch pulse
- i_tx_active  input  1  from uart_tx o_tx_active
- i_tx_done  input  1  from uart_tx o_tx_done
- o_count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
- o_empty  output  1  o_count == 0
- o_full  output  1  o_count == 2**DEPTH_LOG2
- o_overflow  output  1  sticky; set when a byte is dropped because the FIFO is full
- i_clear_overflow  input  1  synchronous clear of o_overflow

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Pointers, o_count, o_rx_ready, o_tx_data_valid, o_overflow all 0.
  - o_tx_byte = 8'h00; o_empty = 1; o_full = 0; both FSMs in their idle states.
  - Memory contents are don't-care.
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap naturally modulo depth. o_count is tracked separately.
- RX FSM:
  - RX_IDLE: on i_rx_data_valid=1, go to RX_ACK and pulse o_rx_ready for exactly the next cycle.
    - If FIFO not full (sampled pre-edge): write i_rx_byte at wr_ptr and increment wr_ptr.
    - If full: byte dropped, o_overflow set.
  - RX_ACK: remain until i_rx_data_valid=0, then go to RX_IDLE. This guarantees one write per received byte.
- TX FSM:
  - TX_IDLE: if !o_empty && !i_tx_active, load o_tx_byte from mem[rd_ptr], increment rd_ptr, pulse o_tx_data_valid one cycle, go to TX_WAIT.
  - TX_WAIT: on i_tx_done, go to TX_IDLE. A new launch is allowed no earlier than the cycle after done.
- Latency: byte sampled at edge k → o_rx_ready high in cycle k+1, o_empty low in k+1 → o_tx_data_valid high in k+2 (when TX idle). Minimum 2 cycles from write to launch.
- Simultaneous push and pop: both occur and o_count is unchanged.
  - Full is judged before the edge, so a push while full is dropped even if a pop happens in the same cycle.
- Overflow: set and clear in the same cycle → set wins.
- Reset mid-operation: an in-flight tx byte is abandoned, the FIFO is emptied, and no launch pulse is emitted after reset.
- Unknown FSM state: recovers to the idle state next cycle.

Optional Feature:
- Macro: UART_FIFO_STATS_EN.
- Defined: adds outputs o_high_water [DEPTH_LOG2:0] (peak o_count since reset or clear) and o_drop_count [15:0] (saturating count of dropped bytes). Both are cleared by i_clear_overflow.
- Not defined: ports and logic are absent; o_overflow is the only error indication.

Decomposition:
- Shared package: RX state encodings (RX_IDLE, RX_ACK), TX state encodings (TX_IDLE, TX_WAIT), default DEPTH_LOG2.
- The top-level BAUD_MULT stays where it is.
- One natural sub-module: fifo_mem_sync (DATA_W x 2**DEPTH_LOG2 register array, one write port, registered read), inferable as iCE40 BRAM.

Test Plan:
1. Reset, then rx valid with byte 8'hA5 held until ack → o_rx_ready pulse 1 cycle; o_tx_data_valid 2 cycles later with o_tx_byte=8'hA5; o_count returns to 0.
2. 16 bytes 8'h00..8'h0F with i_tx_active held 1 → o_full=1, o_count=16. Release tx and pulse i_tx_done per byte → bytes emerge in order 8'h00..8'h0F.
3. FIFO full, 17th byte 8'hFF → still acked, o_overflow=1, o_count stays 16, 8'hFF never transmitted. i_clear_overflow → o_overflow=0.
4. i_rx_data_valid held 5 cycles for one byte → exactly one write, o_count increments by 1.
5. Push 8'h33 in the same cycle as a pop with o_count=3 → o_count stays 3. Pointer wrap after 20 total bytes keeps data order intact.
6. Assert i_rst_n=0 while in TX_WAIT with o_count=5 → all outputs at reset values immediately; no o_tx_data_valid after release until a new byte arrives.
